// File: rtl/mix_pipe_pkg.sv
// Shared definitions for the combine-and-rotate pipeline: modes, flag bit
// positions and a width-generic rotate-left helper.
package mix_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_XOR = 2'd0,
    MODE_SUM = 2'd1,
    MODE_MAX = 2'd2,
    MODE_AND = 2'd3
  } mode_e;

  localparam int FLAG_PARITY = 0;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_OVF    = 2;

  // rotl works on a fixed-size carrier; callers zero-extend in and truncate out.
  localparam int ROT_MAX_W = 128;
  localparam int ROT_IDX_W = $clog2(ROT_MAX_W);

  // Rotate the low w bits of d left by n; bits at and above w come back as 0.
  function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] d,
                                                input int w, input int n);
    logic [ROT_MAX_W-1:0] r;
    int s;
    r = '0;
    s = n % w;
    for (int i = 0; i < ROT_MAX_W; i++)
      if (i < w) r[ROT_IDX_W'(i)] = d[ROT_IDX_W'((i + w - s) % w)];
    return r;
  endfunction

endpackage

// File: rtl/mix_pipe_stage.sv
// One post-combine register stage: carries {valid, data, ovf, tag}, holds on
// a global stall and optionally rotates the data left by one bit as it enters.
module mix_pipe_stage
  import mix_pipe_pkg::*;
#(
  parameter int WIDTH  = 21,
  parameter int TAG_W  = 8,
  parameter bit ROTATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             prev_ovf,
  input  logic [TAG_W-1:0] prev_tag,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ovf,
  output logic [TAG_W-1:0] tag
);

  logic [WIDTH-1:0] next_data;

  // Value entering this stage: rotated by one or passed straight through
  always_comb begin
    next_data = prev_data;
    if (ROTATE) next_data = WIDTH'(rotl(ROT_MAX_W'(prev_data), WIDTH, 1));
  end

  // Shift on advance, hold everything (bubbles included) on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      ovf   <= 1'b0;
      tag   <= '0;
    end else if (advance) begin
      valid <= prev_valid;
      data  <= next_data;
      ovf   <= prev_ovf;
      tag   <= prev_tag;
    end
  end

endmodule

// File: rtl/mix_pipe_stage_n.sv
// Multi-channel combine-and-rotate pipeline with a global stall. Stage 0
// combines CHANNELS words by mode and stamps a sequence tag; STAGES-1 further
// stages rotate the word; flags are derived from the final register.
module mix_pipe_stage_n
  import mix_pipe_pkg::*;
#(
  parameter int WIDTH    = 21,
  parameter int CHANNELS = 2,
  parameter int STAGES   = 4,
  parameter bit ROTATE   = 1'b1,
  parameter int TAG_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic [2:0]                out_flags
);

  logic                         advance;
  logic [STAGES-1:0]            vld;
  logic [STAGES-1:0][WIDTH-1:0] dat;
  logic [STAGES-1:0]            ovf;
  logic [STAGES-1:0][TAG_W-1:0] tag;

  logic             s0_valid;
  logic [WIDTH-1:0] s0_data;
  logic             s0_ovf;
  logic [TAG_W-1:0] s0_tag;
  logic [TAG_W-1:0] tag_cnt;

  logic [WIDTH-1:0] comb_data;
  logic             comb_ovf;
  logic [WIDTH-1:0] ch;
  logic [WIDTH:0]   sum;

  // Only a held, unconsumed result stalls the pipe; bubbles never do.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Stage-0 combine across channels in index order; SUM tracks any carry-out
  always_comb begin
    comb_data = in_data[WIDTH-1:0];
    comb_ovf  = 1'b0;
    ch        = '0;
    sum       = '0;
    for (int c = 1; c < CHANNELS; c++) begin
      ch = in_data[c*WIDTH +: WIDTH];
      case (mode_e'(in_mode))
        MODE_XOR: comb_data = comb_data ^ ch;
        MODE_SUM: begin
          sum       = {1'b0, comb_data} + {1'b0, ch};
          comb_data = sum[WIDTH-1:0];
          comb_ovf  = comb_ovf | sum[WIDTH];
        end
        MODE_MAX: if (ch > comb_data) comb_data = ch;
        MODE_AND: comb_data = comb_data & ch;
        default:  comb_data = comb_data;
      endcase
    end
  end

  // Stage-0 register; the tag is taken and the counter bumped only on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s0_ovf   <= 1'b0;
      s0_tag   <= '0;
      tag_cnt  <= '0;
    end else if (advance) begin
      s0_valid <= in_valid;
      s0_data  <= comb_data;
      s0_ovf   <= comb_ovf;
      s0_tag   <= tag_cnt;
      if (in_valid) tag_cnt <= tag_cnt + 1'b1;
    end
  end

  assign vld[0] = s0_valid;
  assign dat[0] = s0_data;
  assign ovf[0] = s0_ovf;
  assign tag[0] = s0_tag;

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    mix_pipe_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .ROTATE(ROTATE)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .prev_valid(vld[k-1]),
      .prev_data (dat[k-1]),
      .prev_ovf  (ovf[k-1]),
      .prev_tag  (tag[k-1]),
      .valid     (vld[k]),
      .data      (dat[k]),
      .ovf       (ovf[k]),
      .tag       (tag[k])
    );
  end

  assign out_valid = vld[STAGES-1];
  assign out_data  = dat[STAGES-1];
  assign out_tag   = tag[STAGES-1];

  // Status flags straight off the final register so they hold with the data
  always_comb begin
    out_flags              = '0;
    out_flags[FLAG_OVF]    = ovf[STAGES-1];
    out_flags[FLAG_ZERO]   = ~|out_data;
    out_flags[FLAG_PARITY] = ^out_data;
  end

endmodule

// File: tb/tb_mix_pipe_stage_n.sv
// Bench for mix_pipe_stage_n: directed cases with literal expectations plus a
// randomized stream checked every cycle against a behavioural model. A second
// instance with TAG_W = 2 shares all inputs to exercise tag wrap.
module tb_mix_pipe_stage_n;

  localparam int W  = 21;
  localparam int CH = 2;
  localparam int ST = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CH*W-1:0] in_data;
  logic [1:0]    in_mode;
  logic          out_ready;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic [2:0]    out_flags;
  logic          in_ready2, out_valid2;
  logic [W-1:0]  out_data2;
  logic [1:0]    out_tag2;
  logic [2:0]    out_flags2;

  always #5 clk = ~clk;

  mix_pipe_stage_n #(.WIDTH(W), .CHANNELS(CH), .STAGES(ST), .ROTATE(1'b1), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_flags(out_flags));

  mix_pipe_stage_n #(.WIDTH(W), .CHANNELS(CH), .STAGES(ST), .ROTATE(1'b1), .TAG_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_tag(out_tag2), .out_flags(out_flags2));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit           v;
    logic [W-1:0] d;
    bit           ovf;
    int           tag;
  } ent_t;

  ent_t pipe[ST];
  int   m_tag = 0;

  function automatic logic [W-1:0] m_rotl(input logic [W-1:0] x, input int n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1 -: W];
  endfunction

  // Combine per mode with plain integer arithmetic
  function automatic void m_combine(input logic [CH*W-1:0] din, input logic [1:0] m,
                                    output logic [W-1:0] r, output bit o);
    longint unsigned acc, chv, md;
    md  = 64'd1 << W;
    acc = longint'(din[W-1:0]);
    o   = 1'b0;
    for (int c = 1; c < CH; c++) begin
      chv = longint'(din >> (c*W)) & (md - 1);
      case (m)
        2'd0: acc = acc ^ chv;
        2'd1: begin acc = acc + chv; if (acc >= md) begin o = 1'b1; acc = acc - md; end end
        2'd2: if (chv > acc) acc = chv;
        default: acc = acc & chv;
      endcase
    end
    r = W'(acc);
  endfunction

  function automatic logic [2:0] m_flags(input logic [W-1:0] d, input bit o);
    return {o, d == '0, ^d};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ST; k++) pipe[k].v = 1'b0;
      m_tag = 0;
    end else if (!(pipe[ST-1].v && !out_ready)) begin
      for (int k = ST-1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0].v = in_valid;
      if (in_valid) begin
        logic [W-1:0] r;
        bit o;
        m_combine(in_data, in_mode, r, o);
        pipe[0].d   = m_rotl(r, ST-1);
        pipe[0].ovf = o;
        pipe[0].tag = m_tag;
        m_tag = (m_tag + 1) % (1 << TW);
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = pipe[ST-1].v;
      check("in_ready", 64'(in_ready), 64'(!(ev && !out_ready)));
      check("out_valid", 64'(out_valid), 64'(ev));
      check("in_ready_t2", 64'(in_ready2), 64'(!(ev && !out_ready)));
      check("out_valid_t2", 64'(out_valid2), 64'(ev));
      if (ev) begin
        check("out_data", 64'(out_data), 64'(pipe[ST-1].d));
        check("out_tag", 64'(out_tag), 64'(pipe[ST-1].tag));
        check("out_flags", 64'(out_flags), 64'(m_flags(pipe[ST-1].d, pipe[ST-1].ovf)));
        check("out_data_t2", 64'(out_data2), 64'(pipe[ST-1].d));
        check("out_tag_t2", 64'(out_tag2), 64'(pipe[ST-1].tag % 4));
        check("out_flags_t2", 64'(out_flags2), 64'(m_flags(pipe[ST-1].d, pipe[ST-1].ovf)));
      end
    end
  end

  // ---------------- output transfer log ----------------
  typedef struct {
    logic [W-1:0]  d;
    logic [2:0]    f;
    logic [TW-1:0] t;
    logic [1:0]    t2;
    int            cyc;
  } obs_t;

  obs_t obs[$];

  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      obs.push_back('{d: out_data, f: out_flags, t: out_tag, t2: out_tag2, cyc: cyc});

  task automatic wait_obs(input string name, input int n, input int budget);
    int g = 0;
    while (obs.size() < n && g < budget) begin @(negedge clk); g++; end
    check(name, 64'(obs.size() >= n), 64'd1);
  endtask

  task automatic get_obs(output obs_t e);
    if (obs.size() > 0) e = obs.pop_front();
    else e = '{d: '0, f: '0, t: '0, t2: '0, cyc: 0};
  endtask

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    int  g = 0;
    bit  acc;
    in_valid = 1'b1;
    in_data  = {b, a};
    in_mode  = m;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; g++;
    end while (!acc && g < 50);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '1;
      1: return '0;
      2: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    obs_t e, e1;
    int   t0;
    bit   rdone;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'b010);
    @(posedge clk); #1 rst = 1'b0;

    // XOR, latency and first tag
    obs.delete();
    t0 = cyc;
    send(21'h000F0, 21'h0000F, 2'd0);
    wait_obs("xor_seen", 1, 20);
    get_obs(e);
    check("xor_data", 64'(e.d), 64'h007F8);
    check("xor_flags", 64'(e.f), 64'b000);
    check("xor_tag", 64'(e.t), 64'd0);
    check("xor_latency", 64'(e.cyc - t0), 64'(ST));

    // SUM wrap with carry-out
    send(21'h1FFFFF, 21'h000001, 2'd1);
    wait_obs("sum_seen", 1, 20);
    get_obs(e);
    check("sum_data", 64'(e.d), 64'h0);
    check("sum_flags", 64'(e.f), 64'b110);
    check("sum_tag", 64'(e.t), 64'd1);

    // MAX then AND back to back from a fresh tag count
    do_reset(); obs.delete();
    send(21'h00010, 21'h10000, 2'd2);
    send(21'h1FFFFF, 21'h00003, 2'd3);
    wait_obs("maxand_seen", 2, 20);
    get_obs(e); get_obs(e1);
    check("max_data", 64'(e.d), 64'h80000);
    check("max_flags", 64'(e.f), 64'b001);
    check("max_tag", 64'(e.t), 64'd0);
    check("and_data", 64'(e1.d), 64'h00018);
    check("and_flags", 64'(e1.f), 64'b000);
    check("and_tag", 64'(e1.t), 64'd1);
    check("maxand_consecutive", 64'(e1.cyc - e.cyc), 64'd1);

    // Backpressure: 3-cycle output stall once the first result shows up
    do_reset(); obs.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send(W'(32'h11 * (i + 1)), W'(32'h300 << i), 2'd0);
      end
      begin
        int g = 0;
        logic [W-1:0] held;
        logic [TW-1:0] held_t;
        while (!out_valid && g < 40) begin @(posedge clk); #1; g++; end
        check("bp_first_result", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        held = out_data; held_t = out_tag;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("bp_in_ready_low", 64'(in_ready), 64'd0);
          check("bp_hold_valid", 64'(out_valid), 64'd1);
          check("bp_hold_data", 64'(out_data), 64'(held));
          check("bp_hold_tag", 64'(out_tag), 64'(held_t));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_obs("bp_all_seen", 6, 40);
    repeat (ST + 2) @(negedge clk);
    check("bp_count", 64'(obs.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      get_obs(e);
      check("bp_tag_order", 64'(e.t), 64'(i));
      check("bp_data", 64'(e.d), 64'(m_rotl(W'(32'h11 * (i + 1)) ^ W'(32'h300 << i), ST-1)));
    end
    @(posedge clk); #1;

    // Reset mid-flight drops work; an offer during reset is ignored
    do_reset(); obs.delete();
    for (int i = 0; i < 3; i++) send(W'(i + 5), W'(i), 2'd1);
    rst = 1'b1; in_valid = 1'b1; in_data = {W'(7), W'(9)}; in_mode = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int s = 0; s < ST; s++) begin
      @(negedge clk);
      check("rstmid_out_valid", 64'(out_valid), 64'd0);
    end
    check("rstmid_no_output", 64'(obs.size()), 64'd0);
    @(posedge clk); #1;
    send(21'h00055, 21'h00011, 2'd0);
    wait_obs("rstmid_seen", 1, 20);
    get_obs(e);
    check("rstmid_tag", 64'(e.t), 64'd0);
    check("rstmid_data", 64'(e.d), 64'h00220);

    // Tag wrap on the 2-bit-tag instance
    do_reset(); obs.delete();
    for (int i = 0; i < 5; i++) send(W'(i), W'(3), 2'd3);
    wait_obs("wrap_seen", 5, 30);
    for (int i = 0; i < 5; i++) begin
      get_obs(e);
      check("wrap_tag2", 64'(e.t2), 64'(i % 4));
      check("wrap_tag8", 64'(e.t), 64'(i));
    end

    // Randomized stream with random backpressure
    do_reset(); obs.delete();
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(pick(), pick(), 2'($urandom_range(0, 3)));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (ST + 4) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
